// File: rtl/branch_predict_resolve.sv
// ID-stage branch resolution with forwarding/load-use stall, plus a tagless BHT/BTB
// feeding IF. Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_predict_resolve #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     if_pc,
  output logic            if_pred_taken,
  output logic [31:0]     if_pred_target,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     id_pc,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [4:0]      id_ex_dest,
  input  logic [4:0]      ex_mem_dest,
  input  logic [4:0]      mem_wb_dest,
  input  logic            id_ex_wen,
  input  logic            ex_mem_wen,
  input  logic            mem_wb_wen,
  input  logic            id_ex_load,
  input  logic            ex_mem_load,
  input  logic [XLEN-1:0] id_ex_data,
  input  logic [XLEN-1:0] ex_mem_data,
  input  logic [XLEN-1:0] mem_wb_data,
  output logic            stall,
  output logic            is_branch,
  output logic            branch_taken,
  output logic [31:0]     branch_addr,
  output logic            redirect,
  output logic [31:0]     redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [5:0]      opcode;
  logic [4:0]      rs_idx;
  logic [4:0]      rt_idx;
  logic [15:0]     imm;
  logic            uses_rt;
  logic            cond;
  logic            resolve;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [31:0]     pc_plus4;

  logic            tbl_valid [DEPTH];
  logic [1:0]      tbl_ctr   [DEPTH];
  logic [29:0]     tbl_tgt   [DEPTH];
  logic [IW-1:0]   if_idx;
  logic [IW-1:0]   id_idx;
  logic [1:0]      cur_ctr;
  logic [1:0]      next_ctr;

  assign opcode = id_instr[31:26];
  assign rs_idx = id_instr[25:21];
  assign rt_idx = id_instr[20:16];
  assign imm    = id_instr[15:0];

  function automatic logic hit(input logic wen, input logic [4:0] dest, input logic [4:0] src);
    return wen && (dest != 5'd0) && (dest == src);
  endfunction

  always_comb begin
    is_branch = 1'b0;
    uses_rt   = 1'b0;
    unique case (opcode)
      OP_BEQ, OP_BNE: begin
        is_branch = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_REGIMM:        is_branch = (rt_idx == 5'd0) || (rt_idx == 5'd1);
      default:          is_branch = 1'b0;
    endcase
  end

  // Youngest in-flight producer wins; register 0 is hardwired to zero.
  always_comb begin
    rs_val = rs_data;
    if (rs_idx == 5'd0)                           rs_val = '0;
    else if (hit(id_ex_wen, id_ex_dest, rs_idx))   rs_val = id_ex_data;
    else if (hit(ex_mem_wen, ex_mem_dest, rs_idx)) rs_val = ex_mem_data;
    else if (hit(mem_wb_wen, mem_wb_dest, rs_idx)) rs_val = mem_wb_data;
  end

  always_comb begin
    rt_val = rt_data;
    if (rt_idx == 5'd0)                           rt_val = '0;
    else if (hit(id_ex_wen, id_ex_dest, rt_idx))   rt_val = id_ex_data;
    else if (hit(ex_mem_wen, ex_mem_dest, rt_idx)) rt_val = ex_mem_data;
    else if (hit(mem_wb_wen, mem_wb_dest, rt_idx)) rt_val = mem_wb_data;
  end

  always_comb begin
    stall = 1'b0;
    if (id_valid && is_branch) begin
      stall = (hit(id_ex_wen, id_ex_dest, rs_idx) && id_ex_load)
           || (hit(ex_mem_wen, ex_mem_dest, rs_idx) && ex_mem_load)
           || (uses_rt && hit(id_ex_wen, id_ex_dest, rt_idx) && id_ex_load)
           || (uses_rt && hit(ex_mem_wen, ex_mem_dest, rt_idx) && ex_mem_load);
    end
  end

  always_comb begin
    cond = 1'b0;
    unique case (opcode)
      OP_BEQ:    cond = (rs_val == rt_val);
      OP_BNE:    cond = (rs_val != rt_val);
      OP_BLEZ:   cond = rs_val[XLEN-1] || (rs_val == '0);
      OP_BGTZ:   cond = !rs_val[XLEN-1] && (rs_val != '0);
      OP_REGIMM: cond = (rt_idx == 5'd0) ? rs_val[XLEN-1] : !rs_val[XLEN-1];
      default:   cond = 1'b0;
    endcase
  end

  assign resolve      = id_valid && !stall;
  assign branch_taken = resolve && is_branch && cond;
  assign pc_plus4     = id_pc + 32'd4;
  assign branch_addr  = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  // A non-branch predicted taken must be pulled back onto the sequential path.
  assign redirect     = resolve && (is_branch ? (cond != id_pred_taken) : id_pred_taken);
  assign redirect_pc  = branch_taken ? branch_addr : pc_plus4;

  assign if_idx         = if_pc[IW+1:2];
  assign id_idx         = id_pc[IW+1:2];
  assign if_pred_taken  = tbl_valid[if_idx] && tbl_ctr[if_idx][1];
  assign if_pred_target = {tbl_tgt[if_idx], 2'b00};

  assign cur_ctr = tbl_ctr[id_idx];

  always_comb begin
    next_ctr = cur_ctr;
    if (cond && cur_ctr != 2'b11)       next_ctr = cur_ctr + 2'd1;
    else if (!cond && cur_ctr != 2'b00) next_ctr = cur_ctr - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_valid[i] <= 1'b0;
        tbl_ctr[i]   <= 2'b01;
        tbl_tgt[i]   <= '0;
      end
    end else if (resolve && is_branch) begin
      tbl_valid[id_idx] <= 1'b1;
      tbl_ctr[id_idx]   <= next_ctr;
      tbl_tgt[id_idx]   <= branch_addr[31:2];
    end else if (resolve && id_pred_taken) begin
      tbl_valid[id_idx] <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && is_branch && stat_branches != 32'hFFFF_FFFF)
        stat_branches <= stat_branches + 32'd1;
      if (redirect && stat_mispredicts != 32'hFFFF_FFFF)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed table-driven bench for branch_predict_resolve: decode, forwarding,
// load-use stall, predictor training/aliasing, async reset, optional stats.
module tb_branch_predict_resolve;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  id_ex_dest, ex_mem_dest, mem_wb_dest;
  logic        id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic        id_ex_load, ex_mem_load;
  logic [31:0] id_ex_data, ex_mem_data, mem_wb_data;
  logic        stall, is_branch, branch_taken, redirect;
  logic [31:0] branch_addr, redirect_pc;
  logic [31:0] stat_branches, stat_mispredicts;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_br = 0;
  int exp_mis = 0;

  branch_predict_resolve #(.XLEN(32), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .rs_data(rs_data), .rt_data(rt_data),
    .id_ex_dest(id_ex_dest), .ex_mem_dest(ex_mem_dest), .mem_wb_dest(mem_wb_dest),
    .id_ex_wen(id_ex_wen), .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
    .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
    .id_ex_data(id_ex_data), .ex_mem_data(ex_mem_data), .mem_wb_data(mem_wb_data),
    .stall(stall), .is_branch(is_branch), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .redirect(redirect), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] instr, pc;
    logic        pred;
    logic [31:0] rs_d, rt_d;
    logic [4:0]  ide_dest, exm_dest, mwb_dest;
    logic        ide_wen, exm_wen, mwb_wen, ide_load, exm_load;
    logic [31:0] ide_data, exm_data, mwb_data;
    logic [31:0] if_pc;
    logic        chk_look, exp_pred;
    logic [31:0] exp_tgt;
    logic        e_stall, e_br, e_tk, e_rd;
    logic [31:0] e_addr, e_rpc;
  } vec_t;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc, input logic pred,
                              input logic [31:0] rs_d, input logic [31:0] rt_d);
    vec_t v;
    v = '{default: '0};
    v.valid = 1'b1; v.instr = instr; v.pc = pc; v.pred = pred; v.rs_d = rs_d; v.rt_d = rt_d;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic st, input logic b, input logic t,
                              input logic [31:0] a, input logic r, input logic [31:0] rp);
    vec_t v;
    v = vi;
    v.e_stall = st; v.e_br = b; v.e_tk = t; v.e_addr = a; v.e_rd = r; v.e_rpc = rp;
    return v;
  endfunction

  function automatic vec_t lk(input vec_t vi, input logic [31:0] ipc, input logic p,
                              input logic [31:0] tg);
    vec_t v;
    v = vi;
    v.if_pc = ipc; v.chk_look = 1'b1; v.exp_pred = p; v.exp_tgt = tg;
    return v;
  endfunction

  // No instruction in ID: pc=0, instr=0 gives branch_addr = redirect_pc = 4.
  function automatic vec_t idle(input logic [31:0] ipc, input logic p, input logic [31:0] tg);
    vec_t v;
    v = '{default: '0};
    v = ex(v, 1'b0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h4);
    return lk(v, ipc, p, tg);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", n, act, expv);
    end
  endtask

  // driver: apply one vector for exactly one rising edge, check mid-cycle
  task automatic apply(input vec_t v, input string n);
    @(negedge clk);
    id_valid = v.valid; id_instr = v.instr; id_pc = v.pc; id_pred_taken = v.pred;
    rs_data = v.rs_d; rt_data = v.rt_d;
    id_ex_dest = v.ide_dest; id_ex_wen = v.ide_wen; id_ex_load = v.ide_load; id_ex_data = v.ide_data;
    ex_mem_dest = v.exm_dest; ex_mem_wen = v.exm_wen; ex_mem_load = v.exm_load; ex_mem_data = v.exm_data;
    mem_wb_dest = v.mwb_dest; mem_wb_wen = v.mwb_wen; mem_wb_data = v.mwb_data;
    if_pc = v.if_pc;
    #2;
    chk({n, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    chk({n, ".is_branch"}, {31'd0, is_branch}, {31'd0, v.e_br});
    chk({n, ".taken"}, {31'd0, branch_taken}, {31'd0, v.e_tk});
    chk({n, ".addr"}, branch_addr, v.e_addr);
    chk({n, ".redirect"}, {31'd0, redirect}, {31'd0, v.e_rd});
    chk({n, ".redirect_pc"}, redirect_pc, v.e_rpc);
    if (v.chk_look) begin
      chk({n, ".pred_taken"}, {31'd0, if_pred_taken}, {31'd0, v.exp_pred});
      chk({n, ".pred_target"}, if_pred_target, v.exp_tgt);
    end
    if (v.valid && v.e_br && !v.e_stall) exp_br++;
    if (v.e_rd) exp_mis++;
  endtask

  task automatic chk_stats(input string n);
`ifdef BRANCH_STATS_EN
    chk({n, ".stat_branches"}, stat_branches, exp_br);
    chk({n, ".stat_mispredicts"}, stat_mispredicts, exp_mis);
`else
    chk({n, ".stat_branches"}, stat_branches, 32'd0);
    chk({n, ".stat_mispredicts"}, stat_mispredicts, 32'd0);
`endif
  endtask

  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BLEZ = 6'b000110;
  localparam logic [5:0] BGTZ = 6'b000111, RIMM = 6'b000001;

  vec_t tbl [10];
  vec_t v;
  logic [31:0] bne_i, bne_ni, beq_f, bgtz_l;

  initial begin
    bne_i  = ins(BNE, 5'd1, 5'd2, 16'h0004);
    beq_f  = ins(BEQ, 5'd3, 5'd4, 16'h0008);
    bgtz_l = ins(BGTZ, 5'd8, 5'd0, 16'h0010);

    tbl[0] = ex(mk(ins(BEQ, 5'd1, 5'd2, 16'h8000), 32'h10, 0, 32'd1, 32'd1), 0, 1, 1, 32'hFFFE_0014, 1, 32'hFFFE_0014);
    tbl[1] = ex(mk(ins(RIMM, 5'd1, 5'd1, 16'h0001), 32'h20, 0, 32'd0, 32'd0), 0, 1, 1, 32'h28, 1, 32'h28);
    tbl[2] = ex(mk(ins(RIMM, 5'd1, 5'd0, 16'h0001), 32'h24, 0, 32'd0, 32'd0), 0, 1, 0, 32'h2C, 0, 32'h28);
    tbl[3] = ex(mk(ins(RIMM, 5'd1, 5'd2, 16'h0000), 32'h30, 1, 32'd0, 32'd0), 0, 0, 0, 32'h34, 1, 32'h34);
    tbl[4] = ex(mk(ins(BLEZ, 5'd1, 5'd0, 16'hFFFF), 32'h50, 0, 32'h8000_0000, 32'd0), 0, 1, 1, 32'h50, 1, 32'h50);
    tbl[5] = ex(mk(ins(BLEZ, 5'd1, 5'd0, 16'hFFFF), 32'h50, 1, 32'd1, 32'd0), 0, 1, 0, 32'h50, 1, 32'h54);
    tbl[6] = ex(mk(ins(BGTZ, 5'd1, 5'd0, 16'h0002), 32'h60, 0, 32'd1, 32'd0), 0, 1, 1, 32'h6C, 1, 32'h6C);
    tbl[7] = ex(mk(ins(RIMM, 5'd1, 5'd0, 16'h0003), 32'h70, 0, 32'hFFFF_FFFF, 32'd0), 0, 1, 1, 32'h80, 1, 32'h80);
    tbl[8] = ex(mk(ins(6'b000000, 5'd1, 5'd2, 16'h0004), 32'h80, 0, 32'd5, 32'd5), 0, 0, 0, 32'h94, 0, 32'h84);
    tbl[9] = ex(mk(ins(BNE, 5'd1, 5'd2, 16'h0004), 32'h90, 0, 32'd5, 32'd5), 0, 1, 0, 32'hA4, 0, 32'h94);

    rst_n = 1'b0;
    v = '{default: '0};
    id_valid = 0; id_instr = 0; id_pc = 0; id_pred_taken = 0; rs_data = 0; rt_data = 0;
    id_ex_dest = 0; id_ex_wen = 0; id_ex_load = 0; id_ex_data = 0;
    ex_mem_dest = 0; ex_mem_wen = 0; ex_mem_load = 0; ex_mem_data = 0;
    mem_wb_dest = 0; mem_wb_wen = 0; mem_wb_data = 0; if_pc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset state, then bne training and counter saturation
    apply(idle(32'h100, 0, 32'h0), "reset");
    chk_stats("reset");
    apply(lk(ex(mk(bne_i, 32'h100, 0, 32'd5, 32'd7), 0, 1, 1, 32'h114, 1, 32'h114), 32'h100, 0, 32'h0), "bne1");
    for (int i = 0; i < 4; i++)
      apply(lk(ex(mk(bne_i, 32'h100, 1, 32'd5, 32'd7), 0, 1, 1, 32'h114, 0, 32'h114), 32'h100, 1, 32'h114),
            $sformatf("bne_t%0d", i));
    apply(ex(mk(bne_i, 32'h100, 1, 32'd7, 32'd7), 0, 1, 0, 32'h114, 1, 32'h104), "bne_nt1");
    apply(idle(32'h0, 1, 32'h114), "alias_ctr10");
    apply(ex(mk(bne_i, 32'h100, 1, 32'd7, 32'd7), 0, 1, 0, 32'h114, 1, 32'h104), "bne_nt2");
    apply(idle(32'h100, 0, 32'h114), "ctr01");
    apply(ex(mk(bne_i, 32'h100, 0, 32'd5, 32'd7), 0, 1, 1, 32'h114, 1, 32'h114), "bne_retrain");
    apply(ex(mk(32'h0, 32'h100, 1, 32'd0, 32'd0), 0, 0, 0, 32'h104, 1, 32'h104), "nonbr_pred");
    apply(idle(32'h100, 0, 32'h114), "valid_cleared");

    // forwarding priority and register 0
    v = mk(beq_f, 32'h208, 0, 32'd0, 32'd9);
    v.ide_dest = 3; v.ide_wen = 1; v.ide_data = 9; v.exm_dest = 3; v.exm_wen = 1; v.exm_data = 4;
    apply(ex(v, 0, 1, 1, 32'h22C, 1, 32'h22C), "fwd_idex");
    v = mk(beq_f, 32'h208, 0, 32'd9, 32'd9);
    v.ide_wen = 1; v.exm_wen = 1; v.mwb_wen = 1; v.ide_data = 1; v.exm_data = 2; v.mwb_data = 3;
    apply(ex(v, 0, 1, 1, 32'h22C, 1, 32'h22C), "fwd_dest0");
    apply(ex(mk(ins(BEQ, 5'd0, 5'd0, 16'h0008), 32'h208, 1, 32'd5, 32'd6), 0, 1, 1, 32'h22C, 0, 32'h22C), "reg0");
    v = mk(ins(BNE, 5'd3, 5'd4, 16'h0008), 32'h208, 0, 32'd1, 32'd1);
    v.exm_dest = 3; v.exm_wen = 1; v.exm_data = 1; v.mwb_dest = 4; v.mwb_wen = 1; v.mwb_data = 2;
    apply(ex(v, 0, 1, 1, 32'h22C, 1, 32'h22C), "fwd_memwb_rt");

    // load-use stall sequence
    v = mk(bgtz_l, 32'h3C, 1, 32'd5, 32'd0);
    v.ide_dest = 8; v.ide_wen = 1; v.ide_load = 1;
    apply(ex(v, 1, 1, 0, 32'h80, 0, 32'h40), "lu_idex");
    v = mk(bgtz_l, 32'h3C, 1, 32'd5, 32'd0);
    v.exm_dest = 8; v.exm_wen = 1; v.exm_load = 1;
    apply(lk(ex(v, 1, 1, 0, 32'h80, 0, 32'h40), 32'h3C, 0, 32'h0), "lu_exmem");
    v = mk(bgtz_l, 32'h3C, 0, 32'd5, 32'd0);
    v.mwb_dest = 8; v.mwb_wen = 1; v.mwb_data = 32'hFFFF_FFFF;
    apply(lk(ex(v, 0, 1, 0, 32'h80, 0, 32'h40), 32'h3C, 0, 32'h0), "lu_memwb");
    apply(idle(32'h3C, 0, 32'h80), "lu_trained");
    v = mk(ins(BLEZ, 5'd8, 5'd9, 16'h0010), 32'h3C, 1, 32'd0, 32'd0);
    v.ide_dest = 9; v.ide_wen = 1; v.ide_load = 1;
    apply(ex(v, 0, 1, 1, 32'h80, 0, 32'h80), "lu_rt_unused");

    // decode / address table
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("t%0d", i));

    apply(idle(32'h208, 1, 32'h22C), "pre_rst");
    chk_stats("pre_rst");

    // asynchronous reset mid-cycle, away from any clock edge
    rst_n = 1'b0;
    #1;
    chk("async_rst.pred_taken", {31'd0, if_pred_taken}, 32'd0);
    chk("async_rst.pred_target", if_pred_target, 32'h0);
    exp_br = 0;
    exp_mis = 0;
    chk_stats("async_rst");
    #1;
    rst_n = 1'b1;

    apply(ex(mk(bne_i, 32'h100, 0, 32'd5, 32'd7), 0, 1, 1, 32'h114, 1, 32'h114), "post_rst_bne");
    apply(idle(32'h100, 1, 32'h114), "post_rst_look");
    chk_stats("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
